// File: rtl/combination_pkg.sv
`default_nettype none
// ============================================================================
// Module  : combination_pkg
// Brief   : Shared data width and ALU opcode encodings for the combination slice.
// Revision: 1.0 - initial release
// ============================================================================
package combination_pkg;

    localparam int XLEN = 32;
    localparam int NREGS = 32;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

endpackage
`default_nettype wire

// File: rtl/combination_if.sv
`default_nettype none
// ============================================================================
// Module  : combination_if
// Brief   : Register-select, ALU-control and zero-flag bundle of the slice.
// Revision: 1.0 - initial release
// ============================================================================
interface combination_if;

    logic [4:0] rr1;
    logic [4:0] rr2;
    logic [4:0] wr;
    logic       rw;
    logic [3:0] ctl;
    logic       zero;

    modport master (
        output rr1, rr2, wr, rw, ctl,
        input  zero
    );

    modport slave (
        input  rr1, rr2, wr, rw, ctl,
        output zero
    );

endinterface
`default_nettype wire

// File: rtl/combination_regfile.sv
`default_nettype none
// ============================================================================
// Module  : regfile
// Brief   : 32-entry register file, two async read ports, one sync write port.
// Revision: 1.0 - initial release
// ============================================================================
module regfile
    import combination_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic [4:0]       i_rd_idx_a,
    input  wire logic [4:0]       i_rd_idx_b,
    output logic      [WIDTH-1:0] o_rd_data_a,
    output logic      [WIDTH-1:0] o_rd_data_b,
    input  wire logic             i_we,
    input  wire logic [4:0]       i_wr_idx,
    input  wire logic [WIDTH-1:0] i_wr_data
);

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];

    // Reset loads each register with its own index so operands are known.
    always_comb begin
        regs_d = regs_q;
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_d[i] = WIDTH'(i);
            end
        end else if (i_we && (i_wr_idx != 5'd0)) begin
            regs_d[i_wr_idx] = i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        regs_q <= regs_d;
    end

    assign o_rd_data_a = (i_rd_idx_a == 5'd0) ? '0 : regs_q[i_rd_idx_a];
    assign o_rd_data_b = (i_rd_idx_b == 5'd0) ? '0 : regs_q[i_rd_idx_b];

endmodule
`default_nettype wire

// File: rtl/combination.sv
`default_nettype none
// ============================================================================
// Module  : combination
// Brief   : Register file plus inline ALU; result writes back, zero flag out.
// Revision: 1.0 - initial release
// ============================================================================
module combination
    import combination_pkg::*;
(
    input  wire logic     clk,
    input  wire logic     rst,
    combination_if.slave  bus
);

    logic [XLEN-1:0] w_op_a;
    logic [XLEN-1:0] w_op_b;
    logic [XLEN-1:0] w_result;

    regfile #(
        .WIDTH (XLEN)
    ) u_regfile (
        .clk         (clk),
        .rst         (rst),
        .i_rd_idx_a  (bus.rr1),
        .i_rd_idx_b  (bus.rr2),
        .o_rd_data_a (w_op_a),
        .o_rd_data_b (w_op_b),
        .i_we        (bus.rw),
        .i_wr_idx    (bus.wr),
        .i_wr_data   (w_result)
    );

    always_comb begin
        w_result = '0;
        case (bus.ctl)
            ALU_AND: w_result = w_op_a & w_op_b;
            ALU_OR:  w_result = w_op_a | w_op_b;
            ALU_ADD: w_result = w_op_a + w_op_b;
            ALU_SUB: w_result = w_op_a - w_op_b;
            ALU_SLT: w_result = {{(XLEN-1){1'b0}}, ($signed(w_op_a) < $signed(w_op_b))};
            ALU_NOR: w_result = ~(w_op_a | w_op_b);
            default: w_result = '0;
        endcase
    end

    assign bus.zero = (w_result == '0);

endmodule
`default_nettype wire

// File: tb/tb_combination.sv
`default_nettype none
// ============================================================================
// Module  : tb_combination
// Brief   : Directed plus random checks of the combination slice against a model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_combination;

    logic clk;
    logic rst;

    combination_if bus ();

    combination dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [31:0] model [32];
    int          n_checks;
    int          n_fail;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return 32'((64'(a) + 64'(b)) % 64'h1_0000_0000);
            4'd6:    return 32'((64'h1_0000_0000 + 64'(a) - 64'(b)) % 64'h1_0000_0000);
            4'd7:    return (sa < sb) ? 32'd1 : 32'd0;
            4'd12:   return ~(a | b);
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] rd(input logic [4:0] idx);
        return (idx == 5'd0) ? 32'd0 : model[idx];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) model[i] = 32'(i);
    endtask

    task automatic check_reg(input int idx, input logic [31:0] exp);
        check($sformatf("x%0d", idx), dut.u_regfile.regs_q[idx], exp);
    endtask

    // Called 1 time unit after a rising edge; zero is sampled mid-cycle.
    task automatic step(input logic r, input logic [4:0] a, input logic [4:0] b,
                        input logic [4:0] w, input logic we, input logic [3:0] op);
        logic [31:0] res;
        rst      = r;
        bus.rr1  = a;
        bus.rr2  = b;
        bus.wr   = w;
        bus.rw   = we;
        bus.ctl  = op;
        res = ref_alu(op, rd(a), rd(b));
        #4;
        check($sformatf("zero op=%h a=%0d b=%0d", op, a, b), 32'(bus.zero), 32'(res == 32'd0));
        @(posedge clk);
        if (!r) model_reset();
        else if (we && w != 5'd0) model[w] = res;
        #1;
    endtask

    task automatic do_reset();
        step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 4'd2);
    endtask

    initial begin
        logic [3:0] ops [6];
        logic [3:0] op;
        n_checks = 0;
        n_fail   = 0;
        ops[0] = 4'd0; ops[1] = 4'd1; ops[2] = 4'd2;
        ops[3] = 4'd6; ops[4] = 4'd7; ops[5] = 4'd12;

        rst = 1'b0;
        bus.rr1 = '0; bus.rr2 = '0; bus.wr = '0; bus.rw = 1'b1; bus.ctl = 4'd2;
        @(posedge clk);
        model_reset();
        #1;
        rst = 1'b1;
        for (int i = 1; i < 32; i++) check_reg(i, 32'(i));
        #4;
        check("zero after reset", 32'(bus.zero), 32'd1);
        @(posedge clk);
        #1;

        step(1'b1, 5'd2, 5'd3, 5'd7, 1'b1, 4'd2);
        check_reg(7, 32'd5);
        step(1'b1, 5'd5, 5'd6, 5'd4, 1'b1, 4'd6);
        check_reg(4, 32'hFFFF_FFFF);
        step(1'b1, 5'd4, 5'd1, 5'd1, 1'b1, 4'd1);
        check_reg(1, 32'hFFFF_FFFF);
        step(1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 4'd6);
        step(1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 4'd1);
        step(1'b1, 5'd2, 5'd3, 5'd0, 1'b1, 4'd2);
        step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 4'd1);
        check("x0 read", dut.u_regfile.o_rd_data_a, 32'd0);

        do_reset();
        step(1'b1, 5'd5, 5'd6, 5'd4, 1'b1, 4'd6);
        step(1'b1, 5'd4, 5'd1, 5'd0, 1'b0, 4'd7);
        step(1'b1, 5'd1, 5'd4, 5'd0, 1'b0, 4'd7);
        // Same-register read-during-write: the add below must see the old x3.
        step(1'b1, 5'd3, 5'd3, 5'd3, 1'b1, 4'd2);
        check_reg(3, 32'd6);

        step(1'b1, 5'd5, 5'd6, 5'd8, 1'b1, 4'd6);
        check_reg(8, 32'hFFFF_FFFF);
        step(1'b0, 5'd2, 5'd3, 5'd8, 1'b1, 4'd2);
        check_reg(8, 32'd8);
        step(1'b1, 5'd2, 5'd3, 5'd0, 1'b0, 4'hF);

        for (int n = 0; n < 400; n++) begin
            op = ops[$urandom_range(0, 5)];
            if ($urandom_range(0, 9) == 0) op = 4'($urandom);
            step(($urandom_range(0, 39) != 0),
                 ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom),
                 ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom),
                 5'($urandom), 1'($urandom), op);
            if (n % 50 == 49) begin
                for (int i = 1; i < 32; i++) check_reg(i, model[i]);
            end
        end
        for (int i = 1; i < 32; i++) check_reg(i, model[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
